// File: rtl/mod_exp_engine.sv
// mod_exp_engine: m^e mod n by MSB-first square-and-multiply over a bit-serial interleaved (Blakley) modular multiplier.
// Ports: clk, reset (sync, active-high); start/m/e/n request (sampled in IDLE only);
//        busy/done handshake, result = m^e mod n, error = illegal modulus (n < 2).
// Build option: define MOD_EXP_SKIP_ZEROS_EN to skip leading zero exponent bits and unneeded multiplies;
//               the default build is constant-time.
module mod_exp_engine #(
  parameter int WIDTH = 256,
  parameter int IDX_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);
`ifdef MOD_EXP_SKIP_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, SCAN, SQR, MUL, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] m_r, e_r, n_r, r, base;
  logic [WIDTH+1:0] acc;
  logic [IDX_W-1:0] idx, cnt;
  logic [WIDTH-1:0] ma, mb, acc_w;
  logic [WIDTH+1:0] nx, sum, s1, s2;
  logic [IDX_W-1:0] j;
  logic a_bit, e_bit, last, mm_end, keep;
  // acc < n and b < n keep 2*acc + b below 3n, so two conditional subtractions fully reduce each step
  always_comb begin
    ma = state == REDUCE ? m_r : r;
    mb = state == REDUCE ? WIDTH'(1) : state == SQR ? r : base;
    j = IDX_W'(WIDTH - 1) - cnt;
    a_bit = |(ma & (WIDTH'(1) << j));
    e_bit = |(e_r & (WIDTH'(1) << idx));
    nx = {2'b00, n_r};
    sum = (acc << 1) + (a_bit ? {2'b00, mb} : '0);
    s1 = sum >= nx ? sum - nx : sum;
    s2 = s1 >= nx ? s1 - nx : s1;
    acc_w = acc[WIDTH-1:0];
    last = idx == '0;
    mm_end = cnt == IDX_W'(WIDTH);
    keep = SKIP || e_bit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m_r <= '0;
      e_r <= '0;
      n_r <= '0;
      r <= '0;
      base <= '0;
      acc <= '0;
      idx <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_r <= m;
          e_r <= e;
          n_r <= n;
          idx <= IDX_W'(WIDTH - 1);
          result <= '0;
          error <= 1'b0;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: if (n_r < WIDTH'(2)) begin
          error <= 1'b1;
          done <= 1'b1;
          state <= DONE;
        end else begin
          r <= WIDTH'(1);
          state <= REDUCE;
        end
        // only entered in the skip build: one cycle per leading exponent bit
        SCAN: begin
          idx <= idx - 1'b1;
          if (e_bit) r <= base;
          if (last) begin
            done <= 1'b1;
            result <= e_bit ? base : r;
            state <= DONE;
          end else if (e_bit) state <= SQR;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: if (!mm_end) begin
          acc <= s2;
          cnt <= cnt + 1'b1;
        end else begin
          acc <= '0;
          cnt <= '0;
          if (state == REDUCE) begin
            base <= acc_w;
            state <= SKIP ? SCAN : SQR;
          end else if (state == SQR && (!SKIP || e_bit)) begin
            r <= acc_w;
            state <= MUL;
          end else begin
            // constant-time MUL always runs but only commits when the exponent bit is set
            r <= keep ? acc_w : r;
            idx <= idx - 1'b1;
            done <= last;
            if (last) result <= keep ? acc_w : r;
            state <= last ? DONE : SQR;
          end
        end
      endcase
    end
  end
endmodule
